// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI slave / CNN core / weight memory and spi_reg_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface spi_reg_ctrl_if #(
  parameter int NREGS  = 16,
  parameter int MEM_AW = 12
);
  logic               spi_done;
  logic [15:0]        spi_data_out;
  logic [15:0]        spi_data_in;
  logic [NREGS*8-1:0] cfg_regs;
  logic               cnn_start;
  logic               cnn_busy;
  logic               cnn_done;
  logic               mem_wr_valid;
  logic [MEM_AW-1:0]  mem_wr_addr;
  logic [7:0]         mem_wr_data;
  logic               mem_wr_ready;

  modport slave (
    input  spi_done, spi_data_out, cnn_busy, cnn_done, mem_wr_ready,
    output spi_data_in, cfg_regs, cnn_start, mem_wr_valid, mem_wr_addr, mem_wr_data
  );

  modport master (
    output spi_done, spi_data_out, cnn_busy, cnn_done, mem_wr_ready,
    input  spi_data_in, cfg_regs, cnn_start, mem_wr_valid, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Command decoder / register controller behind the 16-bit SPI slave.
// Word: bit15 write, bits14:8 address, bits7:0 write data. Each word is
// executed one cycle after it is latched; the response word (read data or
// write echo) is ready for the next SPI transfer. MEM_DATA writes stream
// bytes to weight memory through an auto-incrementing pointer.
// NREGS / MEM_AW must match the parameters of the connected interface.
module spi_reg_ctrl #(
  parameter int NREGS  = 16,
  parameter int MEM_AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_reg_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT} state_t;

  localparam logic [6:0] A_CTRL   = 7'h00;
  localparam logic [6:0] A_STATUS = 7'h01;
  localparam logic [6:0] A_PTR_LO = 7'h02;
  localparam logic [6:0] A_PTR_HI = 7'h03;
  localparam logic [6:0] A_MEM    = 7'h04;
  localparam logic [6:0] A_CFG    = 7'h10;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_cmd;
  logic [15:0]        r_resp;
  logic [NREGS*8-1:0] r_cfg;
  logic [MEM_AW-1:0]  r_ptr;
  logic               r_done;
  logic               r_err;
  logic               r_start;

  logic               w_wr;
  logic [6:0]         w_addr;
  logic [7:0]         w_wdata;
  logic               w_exec;
  logic               w_mem_wait;
  logic               w_accept;
  logic               w_cfg_hit;
  logic [6:0]         w_cfg_idx;
  logic               w_ctrl_wr;
  logic               w_start_ok;
  logic               w_start_rej;
  logic               w_err_set;
  logic [15:0]        w_ptr16;
  logic [7:0]         w_rdata;

  // State register; async reset also drops mem_wr_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: words arriving outside IDLE are dropped (flagged as ERR).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.spi_done) w_state_nxt = S_EXEC;
      S_EXEC:     w_state_nxt = (r_cmd[15] && r_cmd[14:8] == A_MEM) ? S_MEM_WAIT : S_IDLE;
      S_MEM_WAIT: if (bus.mem_wr_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output/decode logic: command fields, CTRL actions and read-data mux.
  always_comb begin
    w_wr        = r_cmd[15];
    w_addr      = r_cmd[14:8];
    w_wdata     = r_cmd[7:0];
    w_exec      = (r_state == S_EXEC);
    w_mem_wait  = (r_state == S_MEM_WAIT);
    w_accept    = w_mem_wait && bus.mem_wr_ready;
    w_cfg_idx   = w_addr - A_CFG;
    w_cfg_hit   = (w_addr >= A_CFG) && (32'(w_addr) < 32'(16 + NREGS));
    w_ctrl_wr   = w_exec && w_wr && (w_addr == A_CTRL);
    w_start_ok  = w_ctrl_wr && w_wdata[0] && !bus.cnn_busy;
    w_start_rej = w_ctrl_wr && w_wdata[0] &&  bus.cnn_busy;
    w_err_set   = (bus.spi_done && (r_state != S_IDLE)) || w_start_rej;
    w_ptr16     = 16'(r_ptr);
    w_rdata     = 8'h00;
    case (w_addr)
      A_STATUS: w_rdata = {5'b0, r_err, r_done, bus.cnn_busy};
      A_PTR_LO: w_rdata = w_ptr16[7:0];
      A_PTR_HI: w_rdata = w_ptr16[15:8];
      default: begin
        for (int k = 0; k < NREGS; k++) begin
          if (w_cfg_hit && (w_cfg_idx == 7'(k))) w_rdata = r_cfg[8*k +: 8];
        end
      end
    endcase
  end

  // Command latch, register writes, response word, start pulse and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd   <= '0;
      r_resp  <= '0;
      r_cfg   <= '0;
      r_ptr   <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_start_ok;
      if (r_state == S_IDLE && bus.spi_done) r_cmd <= bus.spi_data_out;
      if (w_exec) begin
        r_resp <= w_wr ? {1'b1, w_addr, w_wdata} : {1'b0, w_addr, w_rdata};
        if (w_wr) begin
          if (w_addr == A_PTR_LO) r_ptr[7:0] <= w_wdata;
          if (w_addr == A_PTR_HI) r_ptr[MEM_AW-1:8] <= w_wdata[MEM_AW-9:0];
          for (int k = 0; k < NREGS; k++) begin
            if (w_cfg_hit && (w_cfg_idx == 7'(k))) r_cfg[8*k +: 8] <= w_wdata;
          end
        end
      end
      if (w_accept) r_ptr <= r_ptr + 1'b1;
    end
  end

  // Sticky DONE/ERR flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= bus.cnn_done | (r_done & ~(w_ctrl_wr & w_wdata[1]));
      r_err  <= w_err_set    | (r_err  & ~(w_ctrl_wr & w_wdata[2]));
    end
  end

  assign bus.spi_data_in  = r_resp;
  assign bus.cfg_regs     = r_cfg;
  assign bus.cnn_start    = r_start;
  assign bus.mem_wr_valid = w_mem_wait;
  assign bus.mem_wr_addr  = r_ptr;
  assign bus.mem_wr_data  = r_cmd[7:0];
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: register access, pointer wrap, memory
// stall, start/done handshake, sticky flags and async reset in MEM_WAIT.
module tb_spi_reg_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  spi_reg_ctrl_if #(.NREGS(16), .MEM_AW(12)) bus ();

  spi_reg_ctrl #(.NREGS(16), .MEM_AW(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one SPI word complete pulse; returns in the EXEC cycle.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    bus.spi_done     = 1'b1;
    bus.spi_data_out = w;
    @(negedge clk);
    bus.spi_done     = 1'b0;
    bus.spi_data_out = 16'h0000;
  endtask

  // Send a word and wait until its results are visible (T+2).
  task automatic xfer(input logic [15:0] w);
    send(w);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.spi_done     = 1'b0;
    bus.spi_data_out = 16'h0000;
    bus.cnn_busy     = 1'b0;
    bus.cnn_done     = 1'b0;
    bus.mem_wr_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_resp",  bus.spi_data_in,  16'h0000);
    check("rst_cfg",   bus.cfg_regs,     128'h0);
    check("rst_start", bus.cnn_start,    1'b0);
    check("rst_valid", bus.mem_wr_valid, 1'b0);
    check("rst_addr",  bus.mem_wr_addr,  12'h000);
    check("rst_wdata", bus.mem_wr_data,  8'h00);
    rst_n = 1'b1;

    // Config register access
    xfer(16'h1000);
    check("rd_cfg0_init", bus.spi_data_in, 16'h1000);
    xfer(16'h90AB);
    check("wr_cfg0_echo", bus.spi_data_in, 16'h90AB);
    check("wr_cfg0_reg",  bus.cfg_regs[7:0], 8'hAB);
    xfer(16'h1000);
    check("rd_cfg0", bus.spi_data_in, 16'h10AB);
    xfer(16'h9F5A);
    check("wr_cfg15_reg", bus.cfg_regs[127:120], 8'h5A);
    xfer(16'h1F00);
    check("rd_cfg15", bus.spi_data_in, 16'h1F5A);
    xfer(16'hA077);
    check("wr_oob_echo", bus.spi_data_in, 16'hA077);
    check("wr_oob_cfg",  bus.cfg_regs, {8'h5A, 112'h0, 8'hAB});
    xfer(16'h2000);
    check("rd_oob", bus.spi_data_in, 16'h2000);
    xfer(16'h0000);
    check("rd_ctrl", bus.spi_data_in, 16'h0000);

    // Pointer setup and wrap across three memory writes
    xfer(16'h82FF);
    xfer(16'h830F);
    xfer(16'h0300);
    check("rd_ptr_hi", bus.spi_data_in, 16'h030F);
    xfer(16'h8411);
    check("mem1_valid", bus.mem_wr_valid, 1'b1);
    check("mem1_addr",  bus.mem_wr_addr, 12'hFFF);
    check("mem1_data",  bus.mem_wr_data, 8'h11);
    check("mem1_echo",  bus.spi_data_in, 16'h8411);
    xfer(16'h8422);
    check("mem2_addr", bus.mem_wr_addr, 12'h000);
    check("mem2_data", bus.mem_wr_data, 8'h22);
    xfer(16'h8433);
    check("mem3_addr", bus.mem_wr_addr, 12'h001);
    check("mem3_data", bus.mem_wr_data, 8'h33);
    xfer(16'h0200);
    check("rd_ptr_lo_wrap", bus.spi_data_in, 16'h0202);
    xfer(16'h0300);
    check("rd_ptr_hi_wrap", bus.spi_data_in, 16'h0300);

    // Memory stall and overrun word
    bus.mem_wr_ready = 1'b0;
    xfer(16'h8455);
    check("stall_valid", bus.mem_wr_valid, 1'b1);
    check("stall_addr",  bus.mem_wr_addr, 12'h002);
    xfer(16'h0100);
    check("stall_valid_hold", bus.mem_wr_valid, 1'b1);
    check("stall_addr_hold",  bus.mem_wr_addr, 12'h002);
    check("stall_data_hold",  bus.mem_wr_data, 8'h55);
    check("stall_resp_hold",  bus.spi_data_in, 16'h8455);
    bus.mem_wr_ready = 1'b1;
    @(negedge clk);
    check("stall_accept_valid", bus.mem_wr_valid, 1'b0);
    check("stall_accept_ptr",   bus.mem_wr_addr, 12'h003);
    xfer(16'h0100);
    check("status_err", bus.spi_data_in, 16'h0104);
    xfer(16'h8004);
    xfer(16'h0100);
    check("status_err_clr", bus.spi_data_in, 16'h0100);

    // Start pulse timing
    send(16'h8001);
    check("start_t1", bus.cnn_start, 1'b0);
    @(negedge clk);
    check("start_t2", bus.cnn_start, 1'b1);
    check("start_echo", bus.spi_data_in, 16'h8001);
    @(negedge clk);
    check("start_t3", bus.cnn_start, 1'b0);

    // Start rejected while busy
    bus.cnn_busy = 1'b1;
    send(16'h8001);
    @(negedge clk);
    check("start_busy_t2", bus.cnn_start, 1'b0);
    @(negedge clk);
    check("start_busy_t3", bus.cnn_start, 1'b0);
    xfer(16'h0100);
    check("status_busy_err", bus.spi_data_in, 16'h0105);
    bus.cnn_busy = 1'b0;
    xfer(16'h8004);

    // DONE set, then set colliding with clear
    @(negedge clk);
    bus.cnn_done = 1'b1;
    @(negedge clk);
    bus.cnn_done = 1'b0;
    xfer(16'h0100);
    check("status_done", bus.spi_data_in, 16'h0102);
    send(16'h8002);
    bus.cnn_done = 1'b1;
    @(negedge clk);
    bus.cnn_done = 1'b0;
    xfer(16'h0100);
    check("done_set_wins", bus.spi_data_in, 16'h0102);
    xfer(16'h8002);
    xfer(16'h0100);
    check("done_clr", bus.spi_data_in, 16'h0100);

    // All CTRL bits together while busy: ERR clear then rejected start sets it
    bus.cnn_busy = 1'b1;
    xfer(16'h8007);
    check("ctrl7_start", bus.cnn_start, 1'b0);
    xfer(16'h0100);
    check("ctrl7_status", bus.spi_data_in, 16'h0105);
    bus.cnn_busy = 1'b0;
    xfer(16'h8004);

    // Async reset while waiting on memory
    bus.mem_wr_ready = 1'b0;
    xfer(16'h8499);
    check("pre_rst_valid", bus.mem_wr_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.mem_wr_valid, 1'b0);
    check("async_rst_addr",  bus.mem_wr_addr, 12'h000);
    check("async_rst_data",  bus.mem_wr_data, 8'h00);
    check("async_rst_cfg",   bus.cfg_regs, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_wr_ready = 1'b1;
    xfer(16'h1000);
    check("post_rst_rd_cfg0", bus.spi_data_in, 16'h1000);
    xfer(16'h0100);
    check("post_rst_status", bus.spi_data_in, 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
